// File: rtl/i2c_slave.sv
// i2c_slave: single-address I2C target with strobe handshakes to host logic.
// Define I2C_SLAVE_CLKSTRETCH_EN to stretch SCL while read data is not ready.
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2,
    parameter int         SETUP_CLKS  = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       I2C_SDA_i,
    output logic       I2C_SDADR0_o,
    input  logic       I2C_SCL_i,
    output logic       I2C_SCLDR0_o,
    output logic       busy_o,
    output logic       rw_o,
    output logic       start_o,
    output logic       stop_o,
    output logic [7:0] rx_data_o,
    output logic       rx_stb_o,
    input  logic       rx_nack_i,
    output logic       tx_req_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_underrun_o
);

`ifdef I2C_SLAVE_CLKSTRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif
    localparam int CW = $clog2(SETUP_CLKS + 2);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_q, sda_q;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;
    logic [6:0] tx_q, tx_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic sda_dr_q, sda_dr_d, scl_dr_q, scl_dr_d;
    logic busy_q, busy_d, rw_q, rw_d, nack_q, nack_d;
    logic start_q, start_d, stop_q, stop_d, rx_stb_q, rx_stb_d;
    logic tx_req_q, tx_req_d, under_q, under_d;
    logic [CW-1:0] setup_cnt_q, setup_cnt_d;
    logic tx_load;

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, addr_match;

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_q;
    assign scl_fall   = ~scl_s & scl_q;
    assign start_det  = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det   = scl_s & scl_q & ~sda_q & sda_s;
    assign addr_match = (shift_q[7:1] == SLAVE_ADDR) && (SLAVE_ADDR != 7'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = IDLE;
        end else if (start_det) begin
            state_d = ADDR;
        end else begin
            unique case (state_q)
                ADDR:
                    if (scl_fall && bitcnt_q == 4'd8)
                        state_d = addr_match ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK:
                    if (scl_fall) state_d = rw_q ? TX_BYTE : RX_BYTE;
                RX_BYTE:
                    if (scl_fall && bitcnt_q == 4'd8) state_d = RX_ACK;
                RX_ACK:
                    if (scl_fall) state_d = nack_q ? WAIT_STOP : RX_BYTE;
                TX_BYTE:
                    if (scl_fall && bitcnt_q == 4'd8) state_d = TX_ACK;
                TX_ACK:
                    if (scl_rise && sda_s) state_d = WAIT_STOP;
                    else if (scl_fall) state_d = TX_BYTE;
                default: ;
            endcase
        end
    end

    always_comb begin
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        rx_data_d   = rx_data_q;
        sda_dr_d    = sda_dr_q;
        scl_dr_d    = scl_dr_q;
        busy_d      = busy_q;
        rw_d        = rw_q;
        nack_d      = nack_q;
        setup_cnt_d = setup_cnt_q;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        rx_stb_d    = 1'b0;
        tx_req_d    = 1'b0;
        under_d     = 1'b0;
        tx_load     = 1'b0;
        if (stop_det) begin
            sda_dr_d    = 1'b0;
            scl_dr_d    = 1'b0;
            setup_cnt_d = '0;
            busy_d      = 1'b0;
            stop_d      = busy_q;
        end else if (start_det) begin
            sda_dr_d    = 1'b0;
            scl_dr_d    = 1'b0;
            setup_cnt_d = '0;
            busy_d      = 1'b0;
            bitcnt_d    = 4'd0;
        end else begin
            if (scl_rise) bitcnt_d = bitcnt_q + 4'd1;
            unique case (state_q)
                ADDR: begin
                    if (scl_rise) shift_d = {shift_q[6:0], sda_s};
                    if (scl_fall && bitcnt_q == 4'd8 && addr_match) begin
                        sda_dr_d = 1'b1;
                        rw_d     = shift_q[0];
                        start_d  = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise && rw_q) tx_req_d = 1'b1;
                    if (scl_fall) begin
                        sda_dr_d = 1'b0;
                        bitcnt_d = 4'd0;
                        tx_load  = rw_q;
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        if (bitcnt_q == 4'd7) begin
                            rx_data_d = {shift_q[6:0], sda_s};
                            rx_stb_d  = 1'b1;
                            nack_d    = rx_nack_i;
                        end
                    end
                    if (scl_fall && bitcnt_q == 4'd8) sda_dr_d = ~nack_q;
                end
                RX_ACK:
                    if (scl_fall) begin
                        sda_dr_d = 1'b0;
                        bitcnt_d = 4'd0;
                        busy_d   = busy_q & ~nack_q;
                    end
                TX_BYTE:
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            sda_dr_d = 1'b0;
                        end else begin
                            sda_dr_d = ~tx_q[6];
                            tx_d     = {tx_q[5:0], 1'b0};
                        end
                    end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) busy_d = 1'b0;
                        else tx_req_d = 1'b1;
                    end
                    if (scl_fall) begin
                        bitcnt_d = 4'd0;
                        tx_load  = 1'b1;
                    end
                end
                default: ;
            endcase
            // Bit 7 of a read byte goes out on the fall that ends the ACK.
            if (tx_load) begin
                if (tx_valid_i) begin
                    tx_d     = tx_data_i[6:0];
                    sda_dr_d = ~tx_data_i[7];
                end else if (STRETCH) begin
                    sda_dr_d = 1'b0;
                    scl_dr_d = 1'b1;
                end else begin
                    tx_d     = 7'h7F;
                    sda_dr_d = 1'b0;
                    under_d  = 1'b1;
                end
            end
            if (STRETCH && scl_dr_q && setup_cnt_q == '0 && tx_valid_i) begin
                tx_d        = tx_data_i[6:0];
                sda_dr_d    = ~tx_data_i[7];
                setup_cnt_d = CW'(SETUP_CLKS);
                if (SETUP_CLKS == 0) scl_dr_d = 1'b0;
            end else if (setup_cnt_q == CW'(1)) begin
                scl_dr_d    = 1'b0;
                setup_cnt_d = '0;
            end else if (setup_cnt_q != '0) begin
                setup_cnt_d = setup_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            bitcnt_q    <= 4'd0;
            shift_q     <= 8'd0;
            tx_q        <= 7'd0;
            rx_data_q   <= 8'd0;
            sda_dr_q    <= 1'b0;
            scl_dr_q    <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            nack_q      <= 1'b0;
            setup_cnt_q <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            rx_stb_q    <= 1'b0;
            tx_req_q    <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], I2C_SCL_i};
            sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], I2C_SDA_i};
            scl_q       <= scl_s;
            sda_q       <= sda_s;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            rx_data_q   <= rx_data_d;
            sda_dr_q    <= sda_dr_d;
            scl_dr_q    <= scl_dr_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            nack_q      <= nack_d;
            setup_cnt_q <= setup_cnt_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            rx_stb_q    <= rx_stb_d;
            tx_req_q    <= tx_req_d;
            under_q     <= under_d;
        end
    end

    assign I2C_SDADR0_o  = sda_dr_q;
    assign I2C_SCLDR0_o  = scl_dr_q;
    assign busy_o        = busy_q;
    assign rw_o          = rw_q;
    assign start_o       = start_q;
    assign stop_o        = stop_q;
    assign rx_data_o     = rx_data_q;
    assign rx_stb_o      = rx_stb_q;
    assign tx_req_o      = tx_req_q;
    assign tx_underrun_o = under_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: I2C master BFM plus scoreboard for i2c_slave.
// Host strobes and master-side observations are checked from queues.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int Q        = 10;
    localparam int SETUP    = 4;
    localparam int EV_START = 1;
    localparam int EV_RX    = 2;
    localparam int EV_STOP  = 3;
    localparam int EV_TXREQ = 4;
    localparam int EV_UNDER = 5;
    localparam int BUS_ACK  = 6;
    localparam int BUS_BYTE = 7;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line, scl_line;
    logic       sdadr, scldr, busy, rw, start, stop, rx_stb, tx_req, under;
    logic       rx_nack = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;

    assign sda_line = sda_m & ~sdadr;
    assign scl_line = scl_m & ~scldr;

    always #10 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2), .SETUP_CLKS(SETUP)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .I2C_SDA_i    (sda_line),
        .I2C_SDADR0_o (sdadr),
        .I2C_SCL_i    (scl_line),
        .I2C_SCLDR0_o (scldr),
        .busy_o       (busy),
        .rw_o         (rw),
        .start_o      (start),
        .stop_o       (stop),
        .rx_data_o    (rx_data),
        .rx_stb_o     (rx_stb),
        .rx_nack_i    (rx_nack),
        .tx_req_o     (tx_req),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_underrun_o(under)
    );

    int    n_tests = 0;
    int    n_fail = 0;
    int    exp_evt[$];
    int    exp_bus[$];
    int    obs_bus[$];
    string chk_name[$];
    int    chk_act[$];
    int    chk_exp[$];
    int    txq[$];
    int    cyc = 0;
    int    late_at = -1;
    int    quiet_err = 0;
    int    scl_err = 0;
    logic  quiet = 1'b0;
    logic  done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Host read-data responder: next byte per tx_req, late byte for stretch.
    always @(negedge clk) begin
        if (tx_req) begin
            if (txq.size() > 0) begin
                tx_data  = 8'(txq.pop_front());
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
        end else if (cyc == late_at) begin
            tx_data  = 8'h96;
            tx_valid = 1'b1;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic ev(input int kind, input int data);
        int code;
        code = kind * 256 + data;
        if (exp_evt.size() == 0) cmp("evt_unexpected", code, 0);
        else cmp("evt", code, exp_evt.pop_front());
    endtask

    always @(negedge clk) begin
        if (quiet && sdadr) quiet_err++;
`ifndef I2C_SLAVE_CLKSTRETCH_EN
        if (scldr) scl_err++;
`endif
        if (start)  ev(EV_START, int'(rw));
        if (rx_stb) ev(EV_RX, int'(rx_data));
        if (stop)   ev(EV_STOP, 0);
        if (tx_req) ev(EV_TXREQ, 0);
        if (under)  ev(EV_UNDER, 0);
        while (obs_bus.size() > 0) begin
            int o;
            o = obs_bus.pop_front();
            if (exp_bus.size() == 0) cmp("bus_unexpected", o, 0);
            else cmp("bus", o, exp_bus.pop_front());
        end
        while (chk_name.size() > 0)
            cmp(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front());
        if (done) begin
            cmp("evt_left", exp_evt.size(), 0);
            cmp("bus_left", exp_bus.size(), 0);
            cmp("quiet_drive", quiet_err, 0);
`ifndef I2C_SLAVE_CLKSTRETCH_EN
            cmp("scl_drive", scl_err, 0);
`endif
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic post(input string name, input int act, input int exp);
        chk_name.push_back(name);
        chk_act.push_back(act);
        chk_exp.push_back(exp);
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        int w;
        sda_m = b;
        wclk(Q);
        scl_m = 1'b1;
        w = 0;
        while (!scl_line && w < 5000) begin
            wclk(1);
            w++;
        end
        if (w >= 5000) post("scl_stuck", 1, 0);
        wclk(Q);
        r = sda_line;
        wclk(Q);
        scl_m = 1'b0;
        wclk(Q);
    endtask

    task automatic do_start();
        if (!scl_m) begin
            sda_m = 1'b1;
            wclk(Q);
            scl_m = 1'b1;
            wclk(Q);
        end
        sda_m = 1'b0;
        wclk(Q);
        scl_m = 1'b0;
        wclk(Q);
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        wclk(Q);
        scl_m = 1'b1;
        wclk(Q);
        sda_m = 1'b1;
        wclk(2 * Q);
    endtask

    task automatic wr(input logic [7:0] b, input logic exp_ack);
        logic r;
        exp_bus.push_back(BUS_ACK * 256 + int'(exp_ack));
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, r);
        obs_bus.push_back(BUS_ACK * 256 + int'(r));
    endtask

    task automatic rd(input logic [7:0] exp_d, input logic mack);
        logic [7:0] d;
        logic       r;
        exp_bus.push_back(BUS_BYTE * 256 + int'(exp_d));
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        obs_bus.push_back(BUS_BYTE * 256 + int'(d));
        bit_xfer(mack, r);
    endtask

    initial begin
        logic r;
        int   w;
        int   n;
        wclk(3);
        post("rst_sdadr", int'(sdadr), 0);
        post("rst_scldr", int'(scldr), 0);
        post("rst_busy", int'(busy), 0);
        post("rst_rxdata", int'(rx_data), 0);
        resetn = 1'b1;
        wclk(5);

        // Write 0x5A to our address
        exp_evt.push_back(EV_START * 256 + 0);
        do_start();
        wr(8'h84, 1'b0);
        post("t1_busy", int'(busy), 1);
        post("t1_rw", int'(rw), 0);
        exp_evt.push_back(EV_RX * 256 + 8'h5A);
        wr(8'h5A, 1'b0);
        exp_evt.push_back(EV_STOP * 256);
        do_stop();
        post("t1_busy_after", int'(busy), 0);

        // Foreign address 0x43: bus never driven
        quiet = 1'b1;
        do_start();
        wr(8'h86, 1'b1);
        wr(8'h11, 1'b1);
        do_stop();
        quiet = 1'b0;
        post("t2_busy", int'(busy), 0);

        // Read 0xC3 (ACK) then 0x3C (NACK)
        txq.push_back(8'hC3);
        txq.push_back(8'h3C);
        exp_evt.push_back(EV_START * 256 + 1);
        exp_evt.push_back(EV_TXREQ * 256);
        exp_evt.push_back(EV_TXREQ * 256);
        do_start();
        wr(8'h85, 1'b0);
        post("t3_rw", int'(rw), 1);
        rd(8'hC3, 1'b0);
        rd(8'h3C, 1'b1);
        wclk(4);
        post("t3_busy", int'(busy), 0);
        post("t3_sda_rel", int'(sdadr), 0);
        do_stop();

        // Host NACKs 0x77; following byte ignored
        exp_evt.push_back(EV_START * 256 + 0);
        exp_evt.push_back(EV_RX * 256 + 8'h77);
        do_start();
        wr(8'h84, 1'b0);
        rx_nack = 1'b1;
        wr(8'h77, 1'b1);
        rx_nack = 1'b0;
        post("t4_busy", int'(busy), 0);
        wr(8'h99, 1'b1);
        do_stop();

`ifdef I2C_SLAVE_CLKSTRETCH_EN
        // No read data ready: SCL held until host supplies 0x96
        exp_evt.push_back(EV_START * 256 + 1);
        exp_evt.push_back(EV_TXREQ * 256);
        do_start();
        wr(8'h85, 1'b0);
        fork
            rd(8'h96, 1'b1);
            begin
                w = 0;
                while (!scldr && w < 200) begin
                    wclk(1);
                    w++;
                end
                post("st_hold", int'(scldr), 1);
                late_at = cyc + 100;
                while (cyc < late_at) wclk(1);
                post("st_held100", int'(scldr), 1);
                n = 0;
                while (scldr && n < 50) begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                end
                post("st_release", n, SETUP + 1);
            end
        join
        do_stop();
`else
        // No read data ready: 0xFF with underrun pulse
        exp_evt.push_back(EV_START * 256 + 1);
        exp_evt.push_back(EV_TXREQ * 256);
        exp_evt.push_back(EV_UNDER * 256);
        do_start();
        wr(8'h85, 1'b0);
        rd(8'hFF, 1'b1);
        do_stop();
`endif

        // Repeated START during bit 5 of read byte 0xE0
        txq.push_back(8'hE0);
        exp_evt.push_back(EV_START * 256 + 1);
        exp_evt.push_back(EV_TXREQ * 256);
        do_start();
        wr(8'h85, 1'b0);
        bit_xfer(1'b1, r);
        bit_xfer(1'b1, r);
        do_start();
        post("t6_sda_rel", int'(sdadr), 0);
        post("t6_busy", int'(busy), 0);
        exp_evt.push_back(EV_START * 256 + 0);
        wr(8'h84, 1'b0);
        exp_evt.push_back(EV_STOP * 256);
        do_stop();
        post("t6_busy_after", int'(busy), 0);

        // Asynchronous reset while ACK is driven
        exp_evt.push_back(EV_START * 256 + 0);
        do_start();
        for (int i = 7; i >= 0; i--) bit_xfer(((8'h84 >> i) & 8'h01) != 0, r);
        sda_m = 1'b1;
        scl_m = 1'b1;
        wclk(Q / 2);
        post("t7_ack_drive", int'(sdadr), 1);
        #3;
        resetn = 1'b0;
        #1;
        post("t7_rst_sda", int'(sdadr), 0);
        post("t7_rst_scl", int'(scldr), 0);
        post("t7_rst_busy", int'(busy), 0);
        wclk(3);
        resetn = 1'b1;
        wclk(10);
        done = 1'b1;
        wclk(10);
    end

endmodule
